pr_dma: RTL and testbench

PR_DMA -- requirements
Module: pr_dma

---
 rtl/pr_dma_pkg.sv | 25 ++
 rtl/pr_dma_regs.sv | 94 +++++++++
 rtl/pr_dma.sv | 130 +++++++++++++
 tb/tb_pr_dma.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pr_dma_pkg.sv
// pr_dma_pkg: shared definitions for the pr_dma word-copy DMA engine.
//   - slave register offsets (Addr[3:2])
//   - CTRL register bit positions
//   - master-side FSM state encoding
package pr_dma_pkg;

   localparam logic [1:0] REG_CTRL = 2'd0;
   localparam logic [1:0] REG_SRC  = 2'd1;
   localparam logic [1:0] REG_DST  = 2'd2;
   localparam logic [1:0] REG_LEN  = 2'd3;

   localparam int unsigned CTRL_START = 0;
   localparam int unsigned CTRL_IE    = 1;
   localparam int unsigned CTRL_DONE  = 2;
   localparam int unsigned CTRL_BUSY  = 3;
   localparam int unsigned CTRL_ABORT = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

endpackage

// File: rtl/pr_dma_regs.sv
// pr_dma_regs: slave register file and decode for pr_dma.
// Ports:
//   clk, sys_rstn      clock / async active-low reset
//   sel, we, wdata     slave register select (Addr[3:2]), write strobe, data
//   rdata              combinational read of the selected register
//   busy               engine not idle; blocks SRC/DST/LEN writes
//   src_inc, dst_inc,  working-register advance strobes from the FSM
//   len_dec, done_set
//   src, dst, len      working registers (word addresses / word count)
//   start, abort       one-cycle CTRL trigger pulses
//   irq                registered DONE & IE
module pr_dma_regs #(
   parameter int unsigned LEN_W = 16
) (
   input  logic             clk,
   input  logic             sys_rstn,
   input  logic [1:0]       sel,
   input  logic             we,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   input  logic             busy,
   input  logic             src_inc,
   input  logic             dst_inc,
   input  logic             len_dec,
   input  logic             done_set,
   output logic [29:0]      src,
   output logic [29:0]      dst,
   output logic [LEN_W-1:0] len,
   output logic             start,
   output logic             abort,
   output logic             irq
);

   import pr_dma_pkg::*;

   logic ie;
   logic done;
   logic wr_ctrl;
   logic wr_cfg;

   assign wr_ctrl = we && (sel == REG_CTRL);
   // Transfer set-up registers are frozen while the engine owns them.
   assign wr_cfg  = we && !busy;
   assign start   = wr_ctrl && wdata[CTRL_START];
   assign abort   = wr_ctrl && wdata[CTRL_ABORT];

   always_ff @(posedge clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         ie   <= 1'b0;
         done <= 1'b0;
         irq  <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            ie <= wdata[CTRL_IE];
            if (!wdata[CTRL_DONE]) done <= 1'b0;
         end
         // Completion overrides a simultaneous software clear.
         if (done_set) done <= 1'b1;
         irq <= done && ie;
      end
   end

   always_ff @(posedge clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         src <= '0;
         dst <= '0;
         len <= '0;
      end else begin
         if (wr_cfg && (sel == REG_SRC)) src <= wdata[31:2];
         else if (src_inc)               src <= src + 30'd1;

         if (wr_cfg && (sel == REG_DST)) dst <= wdata[31:2];
         else if (dst_inc)               dst <= dst + 30'd1;

         if (wr_cfg && (sel == REG_LEN)) len <= wdata[LEN_W-1:0];
         else if (len_dec)               len <= len - LEN_W'(1);
      end
   end

   always_comb begin
      rdata = '0;
      case (sel)
         REG_CTRL: begin
            rdata[CTRL_IE]   = ie;
            rdata[CTRL_DONE] = done;
            rdata[CTRL_BUSY] = busy;
         end
         REG_SRC: rdata = {src, 2'b00};
         REG_DST: rdata = {dst, 2'b00};
         default: rdata[LEN_W-1:0] = len;
      endcase
   end

endmodule

// File: rtl/pr_dma.sv
// pr_dma: single-channel word-copy DMA engine.
// Copies LEN words from SRC to DST, one read then one write per word,
// over a request/grant master port; raises DONE (and IRQ if IE) at the end.
// Ports:
//   clk, sys_rstn           clock / async active-low reset
//   Addr, WE, Din, Dout     slave register port (Addr[3:2] decoded)
//   IRQ                     level completion interrupt
//   m_req, m_gnt            master bus request / grant
//   PrAddr, PrWD, PrWe,     master word address, write data, write enable,
//   PrBE, PrRD              byte enables, read data (valid in granted cycle)
module pr_dma #(
   parameter int unsigned LEN_W = 16
) (
   input  logic        clk,
   input  logic        sys_rstn,
   input  logic [31:2] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ,
   output logic        m_req,
   input  logic        m_gnt,
   output logic [31:2] PrAddr,
   output logic [31:0] PrWD,
   output logic        PrWe,
   output logic [3:0]  PrBE,
   input  logic [31:0] PrRD
);

   import pr_dma_pkg::*;

   state_t           state;
   state_t           state_next;
   logic [31:0]      data_buf;
   logic             buf_load;
   logic             busy;
   logic             src_inc;
   logic             dst_inc;
   logic             len_dec;
   logic             done_set;
   logic             start;
   logic             abort;
   logic [29:0]      src;
   logic [29:0]      dst;
   logic [LEN_W-1:0] len;
   logic             unused_addr;

   assign unused_addr = ^Addr[31:4];
   assign busy        = (state != ST_IDLE);

   pr_dma_regs #(.LEN_W(LEN_W)) u_regs (
      .clk      (clk),
      .sys_rstn (sys_rstn),
      .sel      (Addr[3:2]),
      .we       (WE),
      .wdata    (Din),
      .rdata    (Dout),
      .busy     (busy),
      .src_inc  (src_inc),
      .dst_inc  (dst_inc),
      .len_dec  (len_dec),
      .done_set (done_set),
      .src      (src),
      .dst      (dst),
      .len      (len),
      .start    (start),
      .abort    (abort),
      .irq      (IRQ)
   );

   always_ff @(posedge clk or negedge sys_rstn) begin
      if (!sys_rstn) state <= ST_IDLE;
      else           state <= state_next;
   end

   always_ff @(posedge clk or negedge sys_rstn) begin
      if (!sys_rstn)     data_buf <= '0;
      else if (buf_load) data_buf <= PrRD;
   end

   // Abort takes priority over a same-cycle grant: the pending access is
   // not accounted, so SRC/DST/LEN still describe the remaining work.
   always_comb begin
      state_next = state;
      buf_load   = 1'b0;
      src_inc    = 1'b0;
      dst_inc    = 1'b0;
      len_dec    = 1'b0;
      done_set   = 1'b0;
      m_req      = 1'b0;
      PrAddr     = '0;
      PrWe       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_next = (len == '0) ? ST_FIN : ST_RD;
         end
         ST_RD: begin
            m_req  = 1'b1;
            PrAddr = src;
            if (abort) begin
               state_next = ST_IDLE;
            end else if (m_gnt) begin
               buf_load   = 1'b1;
               src_inc    = 1'b1;
               state_next = ST_WR;
            end
         end
         ST_WR: begin
            m_req  = 1'b1;
            PrAddr = dst;
            PrWe   = m_gnt;
            if (abort) begin
               state_next = ST_IDLE;
            end else if (m_gnt) begin
               dst_inc    = 1'b1;
               len_dec    = 1'b1;
               state_next = (len == LEN_W'(1)) ? ST_FIN : ST_RD;
            end
         end
         default: begin
            done_set   = 1'b1;
            state_next = ST_IDLE;
         end
      endcase
   end

   assign PrWD = data_buf;
   assign PrBE = m_req ? 4'b1111 : 4'b0000;

endmodule

// File: tb/tb_pr_dma.sv
// tb_pr_dma: directed self-checking bench for pr_dma.
module tb_pr_dma;

   logic        clk;
   logic        sys_rstn;
   logic [31:2] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;
   logic        m_req;
   logic        m_gnt;
   logic [31:2] PrAddr;
   logic [31:0] PrWD;
   logic        PrWe;
   logic [3:0]  PrBE;
   logic [31:0] PrRD;

   int checks   = 0;
   int failures = 0;

   pr_dma #(.LEN_W(16)) dut (
      .clk      (clk),
      .sys_rstn (sys_rstn),
      .Addr     (Addr),
      .WE       (WE),
      .Din      (Din),
      .Dout     (Dout),
      .IRQ      (IRQ),
      .m_req    (m_req),
      .m_gnt    (m_gnt),
      .PrAddr   (PrAddr),
      .PrWD     (PrWD),
      .PrWe     (PrWe),
      .PrBE     (PrBE),
      .PrRD     (PrRD)
   );

   // Memory model: every word reads as a fixed pattern of its byte address.
   assign PrRD = 32'hC0DE0000 ^ {PrAddr, 2'b00};

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reg(input string tag, input logic [1:0] sel, input logic [31:0] exp);
      Addr = {28'd0, sel};
      #1;
      chk(tag, Dout, exp);
   endtask

   task automatic wr_reg(input logic [1:0] sel, input logic [31:0] d);
      Addr = {28'd0, sel};
      Din  = d;
      WE   = 1'b1;
      tick();
      WE   = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] idx;
      logic        rd;
      logic        g;

      sys_rstn = 1'b0;
      Addr     = '0;
      WE       = 1'b0;
      Din      = '0;
      m_gnt    = 1'b0;
      #2;
      chk("rst_req", m_req, 0);
      chk("rst_be", PrBE, 0);
      chk("rst_addr", {PrAddr, 2'b00}, 0);
      chk("rst_irq", IRQ, 0);
      chk_reg("rst_ctrl", 2'd0, 0);
      chk_reg("rst_len", 2'd3, 0);
      tick();
      sys_rstn = 1'b1;
      tick();
      #1;
      chk("rel_req", m_req, 0);

      // Scenario 1: 3-word copy, grant always high, IE set.
      wr_reg(2'd1, 32'h100);
      wr_reg(2'd2, 32'h200);
      wr_reg(2'd3, 32'd3);
      m_gnt = 1'b1;
      wr_reg(2'd0, 32'h3);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("s1_rd_req", m_req, 1);
         chk("s1_rd_addr", {PrAddr, 2'b00}, 32'h100 + 32'(4 * k));
         chk("s1_rd_be", PrBE, 4'hF);
         chk("s1_rd_we", PrWe, 0);
         tick();
         #1;
         chk("s1_wr_addr", {PrAddr, 2'b00}, 32'h200 + 32'(4 * k));
         chk("s1_wr_we", PrWe, 1);
         chk("s1_wr_data", PrWD, 32'hC0DE0100 + 32'(4 * k));
         tick();
      end
      // In FIN: a CTRL write clearing DONE collides with the set.
      Addr = '0;
      Din  = 32'h2;
      WE   = 1'b1;
      #1;
      chk("s1_fin_req", m_req, 0);
      chk("s1_fin_ctrl", Dout, 32'hA);
      tick();
      WE = 1'b0;
      #1;
      chk("s1_done_ctrl", Dout, 32'h6);
      chk("s1_irq_early", IRQ, 0);
      tick();
      #1;
      chk("s1_irq", IRQ, 1);
      chk_reg("s1_src", 2'd1, 32'h10C);
      chk_reg("s1_dst", 2'd2, 32'h20C);
      chk_reg("s1_len", 2'd3, 0);
      wr_reg(2'd0, 32'h2);
      #1;
      chk("s1_clr_ctrl", Dout, 32'h2);
      chk("s1_clr_irq_lag", IRQ, 1);
      tick();
      #1;
      chk("s1_clr_irq", IRQ, 0);

      // Scenario 2: same copy with grant pattern 1,0,0 repeating.
      wr_reg(2'd1, 32'h100);
      wr_reg(2'd2, 32'h200);
      wr_reg(2'd3, 32'd3);
      wr_reg(2'd0, 32'h1);
      for (int c = 0; c < 16; c++) begin
         g     = (c % 3 == 0);
         m_gnt = g;
         #1;
         a   = 32'((c + 2) / 3);
         rd  = (a[0] == 1'b0);
         idx = a >> 1;
         chk("s2_req", m_req, 1);
         chk("s2_addr", {PrAddr, 2'b00}, rd ? 32'h100 + 4 * idx : 32'h200 + 4 * idx);
         chk("s2_we", PrWe, (!rd && g));
         if (!rd) chk("s2_data", PrWD, 32'hC0DE0100 + 4 * idx);
         tick();
      end
      #1;
      chk("s2_fin_req", m_req, 0);
      chk("s2_fin_ctrl", Dout, 32'h8);
      tick();
      #1;
      chk("s2_done_ctrl", Dout, 32'h4);
      chk_reg("s2_dst", 2'd2, 32'h20C);

      // Scenario 3: zero-length start.
      m_gnt = 1'b1;
      wr_reg(2'd0, 32'h1);
      #1;
      chk("s3_fin_req", m_req, 0);
      chk("s3_fin_ctrl", Dout, 32'h8);
      tick();
      #1;
      chk("s3_req", m_req, 0);
      chk("s3_done_ctrl", Dout, 32'h4);

      // Scenario 4: source wraps past the top of the address space.
      wr_reg(2'd1, 32'hFFFFFFFC);
      wr_reg(2'd2, 32'h300);
      wr_reg(2'd3, 32'd2);
      wr_reg(2'd0, 32'h1);
      #1;
      chk("s4_rd0", {PrAddr, 2'b00}, 32'hFFFFFFFC);
      Addr = {28'd0, 2'd3};
      Din  = 32'h55;
      WE   = 1'b1;
      tick();
      WE   = 1'b0;
      Addr = '0;
      #1;
      chk("s4_wr0", {PrAddr, 2'b00}, 32'h300);
      chk("s4_wd0", PrWD, 32'h3F21FFFC);
      chk("s4_we0", PrWe, 1);
      tick();
      #1;
      chk("s4_rd1", {PrAddr, 2'b00}, 32'h0);
      tick();
      #1;
      chk("s4_wr1", {PrAddr, 2'b00}, 32'h304);
      chk("s4_wd1", PrWD, 32'hC0DE0000);
      tick();
      #1;
      chk("s4_fin_req", m_req, 0);
      tick();
      #1;
      chk("s4_done_ctrl", Dout, 32'h4);
      chk_reg("s4_src", 2'd1, 32'h4);
      chk_reg("s4_len", 2'd3, 0);
      chk_reg("s4_dst", 2'd2, 32'h308);

      // Scenario 5: abort during second write of a 4-word copy.
      wr_reg(2'd1, 32'h100);
      wr_reg(2'd2, 32'h200);
      wr_reg(2'd3, 32'd4);
      wr_reg(2'd0, 32'h1);
      #1;
      chk("s5_rd0", {PrAddr, 2'b00}, 32'h100);
      tick();
      #1;
      chk("s5_wr0", {PrAddr, 2'b00}, 32'h200);
      tick();
      #1;
      chk("s5_rd1", {PrAddr, 2'b00}, 32'h104);
      tick();
      #1;
      chk("s5_wr1", {PrAddr, 2'b00}, 32'h204);
      chk("s5_wr1_we", PrWe, 1);
      Addr = '0;
      Din  = 32'h10;
      WE   = 1'b1;
      tick();
      WE = 1'b0;
      #1;
      chk("s5_abort_req", m_req, 0);
      chk("s5_abort_we", PrWe, 0);
      chk("s5_abort_ctrl", Dout, 32'h0);
      chk_reg("s5_len", 2'd3, 32'd3);
      chk_reg("s5_src", 2'd1, 32'h108);
      chk_reg("s5_dst", 2'd2, 32'h204);

      // Abort while idle changes nothing but IE.
      wr_reg(2'd0, 32'h12);
      #1;
      chk("s5_idle_abort_ctrl", Dout, 32'h2);
      chk("s5_idle_abort_req", m_req, 0);
      chk_reg("s5_idle_abort_len", 2'd3, 32'd3);

      // Reset in the middle of a read.
      wr_reg(2'd0, 32'h1);
      #1;
      chk("s5_rst_pre_req", m_req, 1);
      chk("s5_rst_pre_addr", {PrAddr, 2'b00}, 32'h108);
      sys_rstn = 1'b0;
      #1;
      chk("s5_rst_req", m_req, 0);
      chk("s5_rst_addr", {PrAddr, 2'b00}, 0);
      chk("s5_rst_be", PrBE, 0);
      chk("s5_rst_we", PrWe, 0);
      chk("s5_rst_irq", IRQ, 0);
      chk_reg("s5_rst_src", 2'd1, 0);
      sys_rstn = 1'b1;
      tick();
      #1;
      chk("s5_post_req", m_req, 0);
      tick();
      #1;
      chk("s5_post_req2", m_req, 0);
      chk_reg("s5_post_ctrl", 2'd0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
